// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver and transmitter: FSM state encoding
// and the oversampling geometry of the baud tick.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    // The tick counter must reach both OVERSAMPLE-1 and SB_TICK-1.
    function automatic int tick_cnt_width(input int sb_tick);
        int w;
        w = $clog2(sb_tick);
        return (w > $clog2(OVERSAMPLE)) ? w : $clog2(OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input, with a
// parameterised reset value so an idle-high line does not look active.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DBIT data bits LSB-first, SB_TICK/16 stop bits,
// 16x oversampled. Define UART_RX_FRAME_ERR_EN to add the frame_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    output logic [7:0] dout,
`ifdef UART_RX_FRAME_ERR_EN
    output logic       frame_err,
`endif
    output logic       rx_done_tick
);

    localparam int SW = tick_cnt_width(SB_TICK);

    localparam logic [SW-1:0] S_ONE       = SW'(1);
    localparam logic [SW-1:0] S_MID       = SW'(MID_TICK);
    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

    logic          rx_s;
    logic [1:0]    state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    b_q, b_d;
    logic [7:0]    dout_q, dout_d;
    logic          done_q, done_d;

    // New bit enters at DBIT-1; bits above DBIT-1 stay zero.
    function automatic logic [7:0] shift_in(input logic [7:0] b, input logic bit_i);
        logic [7:0] r;
        r          = b >> 1;
        r[DBIT-1]  = bit_i;
        return r;
    endfunction

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = shift_in(b_q, rx_s);
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            default: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        state_d = ST_IDLE;
                        s_d     = '0;
                        dout_d  = b_q;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;

`ifdef UART_RX_FRAME_ERR_EN
    logic ferr_smp_q;
    logic ferr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ferr_smp_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            if (s_tick && (state_q == ST_STOP) && (s_q == S_MID)) begin
                ferr_smp_q <= ~rx_s;
            end
            ferr_q <= done_d & ferr_smp_q;
        end
    end

    assign frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: DBIT=8 and DBIT=7 instances, directed frames,
// expectations queued at stimulus time and popped by per-instance monitors.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx8, rx7;
    logic       s_tick;
    logic [7:0] dout8, dout7;
    logic       done8, done7;
`ifdef UART_RX_FRAME_ERR_EN
    logic       ferr8, ferr7;
`endif

    int checks = 0;
    int errors = 0;

    int tick_per = 16;
    bit jitter   = 1'b0;

    // {care_ferr, ferr, data}
    logic [9:0] q8[$];
    logic [9:0] q7[$];
    logic [9:0] m8_e;
    logic [9:0] m7_e;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx8),
        .s_tick       (s_tick),
        .dout         (dout8),
`ifdef UART_RX_FRAME_ERR_EN
        .frame_err    (ferr8),
`endif
        .rx_done_tick (done8)
    );

    uart_rx #(.DBIT(7), .SB_TICK(16)) dut7 (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx7),
        .s_tick       (s_tick),
        .dout         (dout7),
`ifdef UART_RX_FRAME_ERR_EN
        .frame_err    (ferr7),
`endif
        .rx_done_tick (done7)
    );

    always #5 clk = ~clk;

    // s_tick generator: one-clk pulse every tick_per clocks, optionally 15/17 jitter
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (tick_per - 1) @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            #1 s_tick = 1'b0;
            if (jitter) tick_per = (tick_per == 15) ? 17 : 15;
            else        tick_per = 16;
        end
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL dut8_unexpected_done: dout=%h, no frame pending", dout8);
            end else begin
                m8_e = q8.pop_front();
                if (dout8 !== m8_e[7:0]) begin
                    errors++;
                    $display("FAIL dut8_dout: got %h, expected %h", dout8, m8_e[7:0]);
                end
`ifdef UART_RX_FRAME_ERR_EN
                if (m8_e[9]) begin
                    checks++;
                    if (ferr8 !== m8_e[8]) begin
                        errors++;
                        $display("FAIL dut8_frame_err: got %b, expected %b", ferr8, m8_e[8]);
                    end
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done7 === 1'b1) begin
            checks++;
            if (q7.size() == 0) begin
                errors++;
                $display("FAIL dut7_unexpected_done: dout=%h, no frame pending", dout7);
            end else begin
                m7_e = q7.pop_front();
                if (dout7 !== m7_e[7:0]) begin
                    errors++;
                    $display("FAIL dut7_dout: got %h, expected %h", dout7, m7_e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic exp8(input logic [7:0] d, input logic care, input logic fe);
        q8.push_back({care, fe, d});
    endtask

    task automatic exp7(input logic [7:0] d);
        q7.push_back({1'b0, 1'b0, d});
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (s_tick !== 1'b1);
        end
        #1;
    endtask

    task automatic set_rx(input int w, input logic v);
        if (w == 8) rx8 = v;
        else        rx7 = v;
    endtask

    task automatic send_frame(input int w, input logic [7:0] d, input int nbits, input bit stop_low);
        set_rx(w, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            set_rx(w, d[i]);
            wait_ticks(16);
        end
        if (stop_low) begin
            set_rx(w, 1'b0);
            wait_ticks(12);
            set_rx(w, 1'b1);
            wait_ticks(20);
        end else begin
            set_rx(w, 1'b1);
            wait_ticks(16);
        end
    endtask

    task automatic wait_drain(input string name);
        int cnt;
        cnt = 0;
        while ((q8.size() != 0 || q7.size() != 0) && cnt < 3000) begin
            @(posedge clk);
            cnt++;
        end
        checks++;
        if (q8.size() != 0 || q7.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: pending8=%0d pending7=%0d, expected 0 and 0",
                     name, q8.size(), q7.size());
            q8.delete();
            q7.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        rx8   = 1'b1;
        rx7   = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_dout8", dout8, 32'h0);
        chk("reset_done8", done8, 32'h0);
        chk("reset_dout7", dout7, 32'h0);
        chk("reset_done7", done7, 32'h0);
        reset = 1'b0;
        wait_ticks(4);

        // single frame
        exp8(8'hA5, 1'b0, 1'b0);
        send_frame(8, 8'hA5, 8, 1'b0);
        wait_drain("a5");
        chk("a5_idle", dut8.state_q, 32'h0);

        // short start glitch
        set_rx(8, 1'b0);
        wait_ticks(4);
        set_rx(8, 1'b1);
        wait_ticks(16);
        chk("glitch_idle", dut8.state_q, 32'h0);
        chk("glitch_dout_held", dout8, 32'hA5);

        // back-to-back frames
        exp8(8'h00, 1'b0, 1'b0);
        exp8(8'hFF, 1'b0, 1'b0);
        send_frame(8, 8'h00, 8, 1'b0);
        send_frame(8, 8'hFF, 8, 1'b0);
        wait_drain("b2b");

        // reset in the middle of 0x3C after three data bits
        set_rx(8, 1'b0);
        wait_ticks(16);
        set_rx(8, 1'b0); wait_ticks(16);
        set_rx(8, 1'b0); wait_ticks(16);
        set_rx(8, 1'b1); wait_ticks(8);
        @(negedge clk);
        reset = 1'b1;
        rx8   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_ticks(40);
        chk("rst_dout", dout8, 32'h0);
        chk("rst_idle", dut8.state_q, 32'h0);
        exp8(8'h81, 1'b0, 1'b0);
        send_frame(8, 8'h81, 8, 1'b0);
        wait_drain("rst_81");

`ifdef UART_RX_FRAME_ERR_EN
        exp8(8'h55, 1'b1, 1'b1);
        send_frame(8, 8'h55, 8, 1'b1);
        exp8(8'hAA, 1'b1, 1'b0);
        send_frame(8, 8'hAA, 8, 1'b0);
        wait_drain("ferr");
`endif

        // 7-bit instance
        exp7(8'h5A);
        send_frame(7, 8'h5A, 7, 1'b0);
        wait_drain("dbit7");

        // jittered tick period
        jitter = 1'b1;
        exp8(8'h3C, 1'b0, 1'b0);
        send_frame(8, 8'h3C, 8, 1'b0);
        exp7(8'h2B);
        send_frame(7, 8'h2B, 7, 1'b0);
        exp8(8'hC3, 1'b0, 1'b0);
        send_frame(8, 8'hC3, 8, 1'b0);
        wait_drain("jitter");
        jitter = 1'b0;

        repeat (20) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
